mux_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4:1 bit mux. It drives the mux's 2-bit select and captures the mux's output bit back, producing one 4-bit frame per scan.
- Each channel is held for a programmable settle (dwell) time.
- The mux output is sampled at the end of that dwell.
- Completed frames are presented to the consumer over a valid/ready handshake.
- Supports single-shot and continuous scan modes.

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_dwell_cnt.sv | 34 +++
 rtl/mux_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and FSM encoding for the 4:1 bit mux and its scan
// sequencer.
//   NCH     - number of mux channels
//   SEL_W   - width of the mux select
//   state_t - scan sequencer FSM states
package mux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell timer for the scan sequencer. Counts enabled cycles and pulses
// done on the cycle whose count is DWELL-1; the count returns to zero
// on that same edge so the next channel starts a fresh dwell.
//   i_clk    - clock, rising edge
//   i_rst_n  - synchronous active-low reset
//   i_clear  - force the count to zero
//   i_enable - count this cycle
//   o_done   - dwell complete (combinational from count and enable)
module mux_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_done = i_enable && (cnt_q == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      cnt_q <= '0;
    end else if (i_enable) begin
      cnt_q <= o_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux. Steps the mux select through every
// channel, holds each for DWELL cycles, samples the mux output at the end
// of the dwell and delivers the assembled 4-bit frame to a consumer.
//   i_clk, i_rst_n    - clock and synchronous active-low reset
//   i_start           - scan request, honoured only in IDLE
//   i_continuous      - rescan after each accepted frame
//   o_sel             - mux select
//   i_mux_out         - mux output bit fed back
//   o_frame           - captured frame, bit k = channel k
//   o_frame_valid     - frame available
//   i_frame_ready     - consumer accepts frame
//   o_busy            - sequencer is not IDLE
//   o_overrun         - sticky: a start arrived while busy
//   o_dbg_state       - current FSM state for observation
//
// Frame handshake: a frame transfers on every rising edge where
// o_frame_valid and i_frame_ready are both high. Once raised, o_frame_valid
// and o_frame stay unchanged until that transfer edge; i_frame_ready has no
// effect while o_frame_valid is low.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_continuous,
  output logic [SEL_W-1:0] o_sel,
  input  logic             i_mux_out,
  output logic [NCH-1:0]   o_frame,
  output logic             o_frame_valid,
  input  logic             i_frame_ready,
  output logic             o_busy,
  output logic             o_overrun,
  output state_t           o_dbg_state
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NCH-1:0]   cap_q, cap_d;
  logic [NCH-1:0]   frame_q, frame_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             dwell_done;

  // The dwell counter only runs in SETTLE and sits at zero elsewhere, so
  // every entry into SETTLE starts a full dwell on channel 0.
  mux_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (state_q != SETTLE),
    .i_enable (state_q == SETTLE),
    .o_done   (dwell_done)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cap_d   = cap_q;
    frame_d = frame_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (i_start) begin
          state_d = SETTLE;
          ovr_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (i_start) ovr_d = 1'b1;
        if (dwell_done) begin
          cap_d[sel_q] = i_mux_out;
          if (sel_q != SEL_LAST) begin
            sel_d = SEL_W'(sel_q + 1'b1);
          end else begin
            // Last channel: the bit sampled this edge goes straight into
            // the frame alongside the three already captured.
            frame_d = {i_mux_out, cap_q[NCH-2:0]};
            valid_d = 1'b1;
            sel_d   = '0;
            state_d = PRESENT;
          end
        end
      end
      PRESENT: begin
        // A start on the handshake edge only counts as an overrun; the
        // handshake decides the next state.
        if (i_start) ovr_d = 1'b1;
        if (i_frame_ready) begin
          valid_d = 1'b0;
          state_d = i_continuous ? SETTLE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cap_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cap_q   <= cap_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_sel         = sel_q;
  assign o_frame       = frame_q;
  assign o_frame_valid = valid_q;
  assign o_busy        = (state_q != IDLE);
  assign o_overrun     = ovr_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;
  import mux_pkg::*;

  localparam int DW = 4;
  localparam int P  = 4 * DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DWELL=4 instance
  logic       start, cont, ready;
  logic [3:0] ch;
  logic [1:0] sel;
  logic       mux_out;
  logic [3:0] frame;
  logic       valid, busy, ovr;
  state_t     st;

  // DWELL=1 instance
  logic       start1, ready1;
  logic [3:0] ch1;
  logic [1:0] sel1;
  logic       mux_out1;
  logic [3:0] frame1;
  logic       valid1, busy1, ovr1;
  state_t     st1;

  // behavioural 4:1 mux: the output bit is the selected channel
  assign mux_out  = ch[sel];
  assign mux_out1 = ch1[sel1];

  mux_scan_ctrl #(.DWELL(DW), .CNT_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_continuous  (cont),
    .o_sel         (sel),
    .i_mux_out     (mux_out),
    .o_frame       (frame),
    .o_frame_valid (valid),
    .i_frame_ready (ready),
    .o_busy        (busy),
    .o_overrun     (ovr),
    .o_dbg_state   (st)
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start1),
    .i_continuous  (1'b0),
    .o_sel         (sel1),
    .i_mux_out     (mux_out1),
    .o_frame       (frame1),
    .o_frame_valid (valid1),
    .i_frame_ready (ready1),
    .o_busy        (busy1),
    .o_overrun     (ovr1),
    .o_dbg_state   (st1)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_frame;
  logic       exp_ovr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One single-shot scan. hold = ready-low cycles after the frame appears;
  // ovr_at = cycle after E0 at which a stray start is seen (-1 = none).
  task automatic do_scan(input logic [3:0] chv, input int hold, input int ovr_at);
    logic [3:0] want;
    @(negedge clk);
    ch = chv; cont = 1'b0; ready = 1'b0; start = 1'b1;
    exp_q.push_back(chv);
    exp_ovr = 1'b0;
    @(posedge clk);  // E0
    for (int n = 0; n < 4 * DW; n++) begin
      @(negedge clk);
      check_eq("scan_sel", sel, n / DW);
      check_eq("scan_busy", busy, 1);
      check_eq("scan_valid", valid, 0);
      check_eq("scan_overrun", ovr, exp_ovr);
      check_eq("scan_frame_hold", frame, last_frame);
      if (n == 0) start = 1'b0;
      if (n == ovr_at - 1) begin start = 1'b1; exp_ovr = 1'b1; end
      if (n == ovr_at) start = 1'b0;
    end
    start = 1'b0;
    want = exp_q.pop_front();
    @(negedge clk);  // after E0+4*DW
    check_eq("present_valid", valid, 1);
    check_eq("present_sel", sel, 0);
    check_eq("present_state", st, 32'(PRESENT));
    for (int h = 0; h < hold; h++) begin
      check_eq("bp_valid", valid, 1);
      check_eq("bp_frame", frame, want);
      check_eq("bp_sel", sel, 0);
      @(negedge clk);
    end
    check_eq("hs_frame", frame, want);
    check_eq("hs_valid", valid, 1);
    check_eq("hs_overrun", ovr, exp_ovr);
    ready = 1'b1;
    @(negedge clk);
    last_frame = want;
    check_eq("post_valid", valid, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_state", st, 32'(IDLE));
    check_eq("post_frame", frame, want);
    ready = 1'b0;
  endtask

  // Continuous scanning with ready held high: a one-cycle valid pulse
  // every P cycles, each carrying that scan's channel values.
  task automatic run_cont(input int nf);
    logic [3:0] fr[8];
    fr[0] = 4'b1101;
    fr[1] = 4'b1001;
    for (int i = 2; i < 8; i++) fr[i] = 4'($urandom_range(0, 15));
    @(negedge clk);
    ch = fr[0]; cont = 1'b1; ready = 1'b1; start = 1'b1;
    @(posedge clk);  // E0
    for (int n = 0; n < P * nf; n++) begin
      int m;
      int k;
      m = n % P;
      k = n / P;
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (m < 4 * DW) begin
        check_eq("cont_sel", sel, m / DW);
        check_eq("cont_valid_lo", valid, 0);
      end else begin
        check_eq("cont_valid_hi", valid, 1);
        check_eq("cont_frame", frame, fr[k]);
        check_eq("cont_sel_present", sel, 0);
        if (k == nf - 1) cont = 1'b0;
        else ch = fr[k + 1];
      end
    end
    @(negedge clk);
    check_eq("cont_end_busy", busy, 0);
    check_eq("cont_end_valid", valid, 0);
    last_frame = fr[nf - 1];
    ready = 1'b0;
  endtask

  // Reset asserted while sel=2: partial frame discarded, all reset values.
  task automatic mid_reset();
    @(negedge clk);
    ch = 4'b1111; start = 1'b1; cont = 1'b0; ready = 1'b0;
    @(posedge clk);  // E0
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
      if (n == 8) begin
        check_eq("pre_rst_sel", sel, 2);
        check_eq("pre_rst_overrun", ovr, 1);
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_frame", frame, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", ovr, 0);
    check_eq("rst_state", st, 32'(IDLE));
    rst_n = 1'b1;
    last_frame = 4'b0000;
  endtask

  task automatic do_scan1(input logic [3:0] chv);
    @(negedge clk);
    ch1 = chv; start1 = 1'b1; ready1 = 1'b1;
    @(posedge clk);  // E0
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0) start1 = 1'b0;
      check_eq("d1_sel", sel1, n);
      check_eq("d1_valid_lo", valid1, 0);
    end
    @(negedge clk);
    check_eq("d1_valid", valid1, 1);
    check_eq("d1_frame", frame1, chv);
    @(negedge clk);
    check_eq("d1_done_valid", valid1, 0);
    check_eq("d1_done_busy", busy1, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b0; ch = 4'b1101;
    start1 = 1'b0; ready1 = 1'b0; ch1 = 4'b0000;
    last_frame = 4'b0000; exp_ovr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_sel", sel, 0);
    check_eq("reset_frame", frame, 0);
    check_eq("reset_valid", valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_overrun", ovr, 0);
    check_eq("reset_state", st, 32'(IDLE));
    check_eq("reset1_frame", frame1, 0);
    rst_n = 1'b1;

    do_scan(4'b1101, 0, -1);           // single scan
    do_scan(4'b1101, 10, -1);          // backpressure
    run_cont(4);                       // continuous
    do_scan(4'b1101, 0, 5);            // overrun mid-scan
    do_scan(4'b1101, 0, -1);           // accepted start clears overrun
    mid_reset();
    do_scan(4'b0000, 0, -1);           // fresh frame after reset
    for (int i = 0; i < 10; i++) begin
      int oa;
      oa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4 * DW - 1)) : -1;
      do_scan(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)), oa);
    end
    do_scan1(4'b1101);
    for (int i = 0; i < 6; i++) do_scan1(4'($urandom_range(0, 15)));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
